// File: rtl/approx_mul_arbiter.sv
// approx_mul_arbiter
//
// Two-requester round-robin arbiter and sequencer for a shared combinational
// 2x2-bit approximate multiplier core. It works as a three-state sequencer:
//   IDLE : one requester is granted, and its operands and ID are latched.
//   EVAL : the core is driven from the operand register, and its output is captured.
//   RESP : the registered response is held until rsp_ready_i.
// The best-case throughput is one result every three cycles.
//
// Optional build macro APPROX_MUL_ERR_MON_EN enables a run-time error monitor.
// The monitor compares each core result with the exact product. It keeps a
// sticky threshold flag, a saturating |error| sum and a saturating sample
// count. Without the macro, the monitor ports, the ET/ACC_W parameters and all
// monitor logic are absent.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_i         synchronous active-high reset
//   req_valid_i   per-requester operand valid (bit i = requester i)
//   req_ready_o   per-requester accept (only the granted bit, only in IDLE)
//   req_a_i       packed operand A, [2i+1:2i] for requester i
//   req_b_i       packed operand B, same packing
//   mul_in_o      core inputs {b[1:0], a[1:0]}
//   mul_out_i     core outputs, combinational from mul_in_o
//   err_clr_i     clears monitor state                 (monitor builds)
//   err_flag_o    sticky |approx - exact| > ET         (monitor builds)
//   err_sum_o     saturating sum of |error|            (monitor builds)
//   sample_cnt_o  saturating count of monitored results (monitor builds)
//   rsp_valid_o   response valid
//   rsp_ready_i   response accept
//   rsp_data_o    captured product
//   rsp_id_o      requester that issued the response

module approx_mul_arbiter
`ifdef APPROX_MUL_ERR_MON_EN
#(
  parameter int unsigned ET    = 8,
  parameter int unsigned ACC_W = 12
)
`endif
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [3:0]       req_a_i,
  input  logic [3:0]       req_b_i,
  output logic [3:0]       mul_in_o,
  input  logic [3:0]       mul_out_i,
`ifdef APPROX_MUL_ERR_MON_EN
  input  logic             err_clr_i,
  output logic             err_flag_o,
  output logic [ACC_W-1:0] err_sum_o,
  output logic [ACC_W-1:0] sample_cnt_o,
`endif
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [3:0]       rsp_data_o,
  output logic             rsp_id_o
);

  typedef enum logic [1:0] {StIdle, StEval, StResp} state_e;

  state_e     state_q, state_d;
  logic       prio_q, prio_d;
  logic [1:0] a_q, a_d;
  logic [1:0] b_q, b_d;
  logic       id_q, id_d;
  logic [3:0] rsp_data_q, rsp_data_d;
  logic       rsp_id_q, rsp_id_d;

  logic gnt;
  logic gnt_vld;

  // The preferred requester wins if it is valid; otherwise the other one
  // wins. This lets a lone requester get every turn.
  always_comb begin
    gnt     = req_valid_i[prio_q] ? prio_q : ~prio_q;
    gnt_vld = |req_valid_i;
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    req_ready_o = 2'b00;

    case (state_q)
      StIdle: begin
        // Reset gating keeps req_ready low in the reset cycle, even though
        // state_q may not yet be back at IDLE.
        if (gnt_vld && !rst_i) begin
          req_ready_o = gnt ? 2'b10 : 2'b01;
          a_d         = gnt ? req_a_i[3:2] : req_a_i[1:0];
          b_d         = gnt ? req_b_i[3:2] : req_b_i[1:0];
          id_d        = gnt;
          prio_d      = ~gnt;
          state_d     = StEval;
        end
      end
      StEval: begin
        rsp_data_d = mul_out_i;
        rsp_id_d   = id_q;
        state_d    = StResp;
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      prio_q     <= 1'b0;
      a_q        <= 2'b00;
      b_q        <= 2'b00;
      id_q       <= 1'b0;
      rsp_data_q <= 4'd0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  // The operand register holds its value between accepts, so the core input
  // is stable for the whole of EVAL.
  assign mul_in_o    = {b_q, a_q};
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;

`ifdef APPROX_MUL_ERR_MON_EN
  logic [3:0]       exact;
  logic [3:0]       err;
  logic [ACC_W:0]   sum_ext;
  logic             err_flag_q, err_flag_d;
  logic [ACC_W-1:0] err_sum_q, err_sum_d;
  logic [ACC_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // The largest exact product is 9, so four bits are enough.
    exact      = {2'b00, a_q} * {2'b00, b_q};
    err        = (mul_out_i >= exact) ? (mul_out_i - exact) : (exact - mul_out_i);
    // One extra bit catches overflow, which then saturates the sum.
    sum_ext    = {1'b0, err_sum_q} + {{(ACC_W - 3){1'b0}}, err};
    err_flag_d = err_flag_q;
    err_sum_d  = err_sum_q;
    cnt_d      = cnt_q;
    if (err_clr_i) begin
      // If a clear and an EVAL sample arrive together, the clear wins and
      // the sample is discarded.
      err_flag_d = 1'b0;
      err_sum_d  = '0;
      cnt_d      = '0;
    end else if (state_q == StEval) begin
      err_sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      if (cnt_q != '1) begin
        cnt_d = cnt_q + {{(ACC_W - 1){1'b0}}, 1'b1};
      end
      if ({28'd0, err} > ET) begin
        err_flag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_flag_q <= 1'b0;
      err_sum_q  <= '0;
      cnt_q      <= '0;
    end else begin
      err_flag_q <= err_flag_d;
      err_sum_q  <= err_sum_d;
      cnt_q      <= cnt_d;
    end
  end

  assign err_flag_o   = err_flag_q;
  assign err_sum_o    = err_sum_q;
  assign sample_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// Self-checking bench for approx_mul_arbiter.
//
// A stub core (exact, or deliberately wrong in selectable ways) closes the loop
// on mul_in/mul_out. A scoreboard works at the falling edge:
//   - On each accept, it pushes the expected {id, product}. The grant itself is
//     checked against a round-robin reference model.
//   - On each response handshake, it pops the entry and compares it.
// Directed checks add reset values, latency, stall stability, reset abort and,
// in monitor builds, the monitor behaviour.

module tb_approx_mul_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [3:0] mul_in;
  logic [3:0] mul_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_id;
`ifdef APPROX_MUL_ERR_MON_EN
  logic        err_clr;
  logic        err_flag;
  logic [11:0] err_sum;
  logic [11:0] sample_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int stub_mode = 0;   // 0 exact, 1 zero for 3x3, 2 exact+1
  int cyc = 0;
  int n_rsp = 0;
  logic mdl_prio = 1'b0;

  logic [4:0] sb_q[$];
  int         rsp_cyc[$];
  logic [4:0] rsp_rec[$];

  always #5 clk = ~clk;

  function automatic logic [3:0] core_model(input logic [1:0] a, input logic [1:0] b,
                                            input int mode);
    logic [3:0] p;
    p = {2'b00, a} * {2'b00, b};
    if (mode == 1 && a == 2'd3 && b == 2'd3) p = 4'd0;
    else if (mode == 2) p = p + 4'd1;
    return p;
  endfunction

  always_comb mul_out = core_model(mul_in[1:0], mul_in[3:2], stub_mode);

  approx_mul_arbiter u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .mul_in_o     (mul_in),
    .mul_out_i    (mul_out),
`ifdef APPROX_MUL_ERR_MON_EN
    .err_clr_i    (err_clr),
    .err_flag_o   (err_flag),
    .err_sum_o    (err_sum),
    .sample_cnt_o (sample_cnt),
`endif
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_id_o     (rsp_id)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard and grant model, sampled at the falling edge.
  task automatic sb_sample();
    logic       g;
    logic [1:0] a;
    logic [1:0] b;
    logic [4:0] e;
    cyc++;
    if (rst) begin
      sb_q.delete();
      mdl_prio = 1'b0;
      return;
    end
    if (rsp_valid) check_eq("ready_in_resp", req_ready, 2'b00);
    if (req_ready != 2'b00) begin
      g = req_valid[mdl_prio] ? mdl_prio : ~mdl_prio;
      check_eq("grant", req_ready, g ? 2'b10 : 2'b01);
      a = g ? req_a[3:2] : req_a[1:0];
      b = g ? req_b[3:2] : req_b[1:0];
      sb_q.push_back({g, core_model(a, b, stub_mode)});
      mdl_prio = ~g;
    end
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      if (sb_q.size() == 0) begin
        check_eq("rsp_unexpected", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_eq("rsp_id", rsp_id, e[4]);
        check_eq("rsp_data", rsp_data, e[3:0]);
        rsp_cyc.push_back(cyc);
        rsp_rec.push_back({rsp_id, rsp_data});
      end
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    sb_sample();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    to_neg();
    to_pos();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (sb_q.size() == 0) break;
      tick();
    end
    check_eq(tag, sb_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 2'b11;
    req_a     = 4'd0;
    req_b     = 4'd0;
    rsp_ready = 1'b0;
`ifdef APPROX_MUL_ERR_MON_EN
    err_clr   = 1'b0;
`endif
    to_pos();
    // Reset values; req_ready must stay low even with both requesters valid.
    to_neg();
    check_eq("rst_req_ready", req_ready, 2'b00);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_mul_in", mul_in, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_rsp_id", rsp_id, 0);
`ifdef APPROX_MUL_ERR_MON_EN
    check_eq("rst_err_flag", err_flag, 0);
    check_eq("rst_err_sum", err_sum, 0);
    check_eq("rst_sample_cnt", sample_cnt, 0);
`endif
    to_pos();

    // Single request 3x3 from requester 0: latency and core drive.
    rst = 1'b0; req_valid = 2'b01; req_a = 4'b0011; req_b = 4'b0011; rsp_ready = 1'b1;
    to_neg();
    check_eq("a_ready", req_ready, 2'b01);
    to_pos();                                   // accept edge T
    req_valid = 2'b00;
    to_neg();
    check_eq("a_eval_mul_in", mul_in, 4'b1111);
    check_eq("a_eval_rsp_valid", rsp_valid, 0);
    to_pos();
    to_neg();
    check_eq("a_rsp_valid_t2", rsp_valid, 1);
    check_eq("a_rsp_data", rsp_data, 9);
    to_pos();
    to_neg();
    check_eq("a_rsp_done", rsp_valid, 0);
    to_pos();

    // Both requesters valid from reset: grants alternate, 3 cycles apart.
    rst = 1'b1; req_valid = 2'b11;
    req_a = {2'd1, 2'd2}; req_b = {2'd2, 2'd3}; rsp_ready = 1'b1;
    tick();
    rst = 1'b0;
    rsp_cyc.delete();
    rsp_rec.delete();
    for (int i = 0; i < 12; i++) tick();
    req_valid = 2'b00;
    drain("b_drain");
    check_eq("b_count_ge4", rsp_rec.size() >= 4, 1);
    if (rsp_rec.size() >= 4) begin
      check_eq("b_first", rsp_rec[0], {1'b0, 4'd6});
      check_eq("b_second", rsp_rec[1], {1'b1, 4'd2});
      check_eq("b_third_id", rsp_rec[2][4], 0);
      check_eq("b_fourth_id", rsp_rec[3][4], 1);
      check_eq("b_spacing", rsp_cyc[1] - rsp_cyc[0], 3);
    end

    // Stall: rsp_ready low for 5 cycles in RESP.
    req_valid = 2'b10; req_a = 4'b1100; req_b = 4'b1000; rsp_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      to_neg();
      if (rsp_valid) break;
      to_pos();
    end
    check_eq("c_rsp_seen", rsp_valid, 1);
    for (int s = 0; s < 5; s++) begin
      check_eq("c_hold_valid", rsp_valid, 1);
      check_eq("c_hold_data", rsp_data, 6);
      check_eq("c_hold_id", rsp_id, 1);
      check_eq("c_hold_ready", req_ready, 2'b00);
      to_pos();
      req_valid = 2'b11;
      to_neg();
    end
    to_pos();
    rsp_ready = 1'b1;
    to_neg();
    check_eq("c_release_valid", rsp_valid, 1);
    to_pos();
    to_neg();
    check_eq("c_after_valid", rsp_valid, 0);
    check_eq("c_after_ready", req_ready, 2'b01);
    to_pos();
    req_valid = 2'b00;
    drain("c_drain");

    // Reset during EVAL drops the operation.
    req_valid = 2'b01; req_a = 4'b0001; req_b = 4'b0001; rsp_ready = 1'b1;
    to_neg();
    check_eq("d_ready", req_ready, 2'b01);
    to_pos();
    rst = 1'b1; req_valid = 2'b00;
    to_neg();
    to_pos();
    rst = 1'b0; req_valid = 2'b01;
    to_neg();
    check_eq("d_no_rsp", rsp_valid, 0);
    check_eq("d_accept_after_rst", req_ready, 2'b01);
    to_pos();
    req_valid = 2'b00;
    to_neg();
    check_eq("d_no_rsp2", rsp_valid, 0);
    to_pos();
    drain("d_drain");
    for (int i = 0; i < 4; i++) tick();

`ifdef APPROX_MUL_ERR_MON_EN
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    to_neg();
    check_eq("m_clr_cnt", sample_cnt, 0);
    to_pos();

    // The stub returns 0 for 3x3, so err = 9 > ET = 8.
    stub_mode = 1;
    req_valid = 2'b01; req_a = 4'b0011; req_b = 4'b0011;
    to_neg();
    to_pos();
    req_valid = 2'b00;
    drain("m_drain");
    to_neg();
    check_eq("m_err_flag", err_flag, 1);
    check_eq("m_err_sum", err_sum, 9);
    check_eq("m_sample_cnt", sample_cnt, 1);
    to_pos();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    to_neg();
    check_eq("m_clr_flag", err_flag, 0);
    check_eq("m_clr_sum", err_sum, 0);
    check_eq("m_clr_cnt2", sample_cnt, 0);
    to_pos();

    // Saturation: 4101 or more samples, each with err = 1.
    stub_mode = 2;
    n_rsp = 0;
    req_valid = 2'b01; req_a = 4'b0001; req_b = 4'b0001;
    for (int i = 0; i < 3 * 4101 + 6; i++) tick();
    req_valid = 2'b00;
    drain("s_drain");
    to_neg();
    check_eq("s_enough_samples", n_rsp >= 4101, 1);
    check_eq("s_err_sum_sat", err_sum, 4095);
    check_eq("s_cnt_sat", sample_cnt, 4095);
    check_eq("s_flag_low", err_flag, 0);
    to_pos();
    stub_mode = 0;
`endif

    check_eq("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/approx_mul_arbiter.md
# approx_mul_arbiter

Round-robin arbiter and sequencer that shares one combinational 2×2-bit approximate multiplier core (4 inputs, 4 outputs) between two requesters. It latches the granted operands, drives the core inputs, captures the core output into a registered response with valid/ready handshake and requester ID. An optional monitor compares every core result against the exact product to track approximation error at run time. It sits between operand producers and the approximate multiplier instance in the datapath.

## Interface
- `ET`, 8, error threshold; `err_flag` sets when |approx − exact| > `ET`
- `ACC_W`, 12, width of error accumulator and sample counter
- `clk` in 1, rising-edge clock
- `rst` in 1, synchronous active-high reset
- `req_valid` in 2, per-requester operand valid (bit i = requester i)
- `req_ready` out 2, per-requester accept
- `req_a` in 4, packed operand A, `req_a[2i+1:2i]` for requester i
- `req_b` in 4, packed operand B, same packing
- `mul_in` out 4, core inputs: `{in3,in2,in1,in0}` = `{b[1:0],a[1:0]}`
- `mul_out` in 4, core outputs `{out3..out0}`, combinational from `mul_in`
- `rsp_valid` out 1, response valid
- `rsp_ready` in 1, response accept
- `rsp_data` out 4, captured product
- `rsp_id` out 1, requester that issued the response
- `err_clr` in 1, clears monitor state (monitor builds only)
- `err_flag` out 1, sticky threshold violation (monitor builds only)
- `err_sum` out ACC_W, saturating sum of |error| (monitor builds only)
- `sample_cnt` out ACC_W, saturating count of monitored results (monitor builds only)

## Operation
- FSM states: IDLE, EVAL, RESP
- IDLE: grant = highest-priority requester with `req_valid`. `prio` pointer selects the preferred requester and is 0 after reset. `req_ready[grant]`=1, other bit 0. On `req_valid & req_ready`: latch `a`, `b`, id into operand register; `prio` ← ~grant; go to EVAL. No valid → stay.
- EVAL: `mul_in` driven from the operand register, which holds its value outside IDLE accepts. Capture `mul_out` → `rsp_data`, id → `rsp_id`; go to RESP.
- RESP: `rsp_valid`=1; `rsp_data` and `rsp_id` stable. On `rsp_ready` → IDLE. Otherwise hold.
- `req_ready`=0 in EVAL and RESP. No request is accepted while a response is pending.
- Monitor, evaluated in EVAL: exact = a×b (4-bit, max 9); err = |mul_out − exact| (4-bit unsigned). `err_sum` += err and `sample_cnt` += 1, both saturating at 2^ACC_W−1. `err_flag` sets if err > ET and stays set until `err_clr` or `rst`.
- `err_clr` in the same cycle as an EVAL update: the clear wins and the sample is discarded.

## Timing
- Reset values: state IDLE, `prio`=0, `req_ready`=0 in the reset cycle, `mul_in`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `err_flag`=0, `err_sum`=0, `sample_cnt`=0.
- Accept at edge T → EVAL during T+1 → `rsp_valid`=1 from T+2.
- `rsp_ready` high on first valid cycle → next accept possible at T+3. Peak throughput is 1 result per 3 cycles.
- `req_ready` is combinational from `req_valid`, `prio` and state. There is no combinational path from `rsp_ready` to `req_ready`.
- `rst` in any state (including EVAL/RESP): the in-flight operation is dropped, there is no response, and all registers return to reset values on the next edge.
- Both requesters valid continuously: grants alternate 0,1,0,1…
- A single requester holding valid is granted every turn, so it does not wait on an idle peer.

## Configuration
- `APPROX_MUL_ERR_MON_EN` defined: exact-product compare, `err_clr`, `err_flag`, `err_sum`, `sample_cnt` are built as specified.
- Not defined: those ports and all monitor logic are absent. Arbitration, FSM and response timing are identical.

## Test plan
- Core stub = exact. Requester 0 sends a=3, b=3, `rsp_ready`=1 → `rsp_valid` at T+2, `rsp_data`=9, `rsp_id`=0, `mul_in`=4'b1111 during EVAL.
- Both valid from reset (r0: 2×3, r1: 1×2), `rsp_ready`=1 → responses `rsp_data`=6 with id 0, then 2 with id 1, 3 cycles apart.
- `rsp_ready` low 5 cycles in RESP → `rsp_valid`, `rsp_data`, `rsp_id` stable and `req_ready`=2'b00 throughout. The response completes on the cycle `rsp_ready` rises.
- Monitor build, stub returns 0 for 3×3, ET=8 → err=9, `err_flag`=1, `err_sum`=9, `sample_cnt`=1. `err_clr` pulse → all 0.
- Monitor build, 2^ACC_W+5 samples each with err=1 → `err_sum` and `sample_cnt` saturate at 4095.
- `rst` asserted during EVAL → no `rsp_valid` afterwards. The state is IDLE and a new request from requester 0 is accepted the cycle after reset deasserts.
